// File: rtl/dual_mode_timer.sv
// dual_mode_timer: countdown / stopwatch timer with a tick prescaler,
// pause/resume, strobe priority and optional auto-reload.
module dual_mode_timer #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4,
  parameter int WRAP     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done
);

  localparam logic [7:0] PRE_MAX = 8'(TICK_DIV - 1);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [7:0]       pre_q, pre_d;
  logic             run_mode_q, run_mode_d;
  logic             term_q, term_d;
  logic             done_q, done_d;
  logic             running_q;

  logic sel_clear, sel_load;
  logic sel_start, sel_pause;

  assign sel_clear = clear;
  assign sel_load  = load & ~clear;
  assign sel_start = start & ~load & ~clear;
  assign sel_pause = pause & ~start & ~load & ~clear;

  // Result of one cycle spent in RUN, before strobes are applied.
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [7:0]       r_pre;
  logic             r_done;
  logic             r_term;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_dec = count_q - WIDTH'(1);
  assign cnt_inc = count_q + WIDTH'(1);

  always_comb begin
    r_state = RUN;
    r_count = count_q;
    r_pre   = pre_q;
    r_done  = 1'b0;
    r_term  = term_q;
    if (term_q) begin
      r_state = DONE;
      r_done  = 1'b1;
      r_term  = 1'b0;
    end else if (pre_q == PRE_MAX) begin
      r_pre = '0;
      if (!run_mode_q) begin
        if (cnt_dec == '0) begin
          r_done = 1'b1;
          if (WRAP_EN) begin
            r_count = last_q;
          end else begin
            r_count = '0;
            r_state = DONE;
          end
        end else begin
          r_count = cnt_dec;
        end
      end else begin
        // Reload mode shows the target for one tick, then restarts at 0.
        if (WRAP_EN && (count_q == target_q)) begin
          r_count = '0;
        end else begin
          r_count = cnt_inc;
        end
        if (r_count == target_q) begin
          r_done = 1'b1;
          if (!WRAP_EN) begin
            r_state = DONE;
          end
        end
      end
    end else begin
      r_pre = pre_q + 8'd1;
    end
  end

  logic run_go;
  logic go_pause;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    last_d     = last_q;
    pre_d      = pre_q;
    run_mode_d = run_mode_q;
    term_d     = term_q;
    done_d     = 1'b0;
    run_go     = 1'b0;
    go_pause   = 1'b0;

    unique case (1'b1)
      sel_clear: begin
        state_d  = IDLE;
        count_d  = '0;
        target_d = '0;
        pre_d    = '0;
        term_d   = 1'b0;
      end
      sel_load: begin
        if (state_q == IDLE || state_q == DONE) begin
          state_d = IDLE;
          if (mode) begin
            target_d = load_value;
            count_d  = '0;
          end else begin
            count_d = load_value;
            last_d  = load_value;
          end
        end else begin
          run_go = (state_q == RUN);
        end
      end
      sel_start: begin
        unique case (state_q)
          IDLE: begin
            state_d    = RUN;
            run_mode_d = mode;
            pre_d      = '0;
            term_d     = mode ? (target_q == '0)
                              : (count_q == '0);
          end
          PAUSED: state_d = RUN;
          RUN:    run_go = 1'b1;
          default: ;
        endcase
      end
      sel_pause: begin
        run_go   = (state_q == RUN);
        go_pause = 1'b1;
      end
      default: begin
        run_go = (state_q == RUN);
      end
    endcase

    // A tick in the pause cycle lands first; a terminal tick wins over pause.
    if (run_go) begin
      count_d = r_count;
      pre_d   = r_pre;
      done_d  = r_done;
      term_d  = r_term;
      if (go_pause && r_state == RUN) begin
        state_d = PAUSED;
      end else begin
        state_d = r_state;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      target_q   <= '0;
      last_q     <= '0;
      pre_q      <= '0;
      run_mode_q <= 1'b0;
      term_q     <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      target_q   <= target_d;
      last_q     <= last_d;
      pre_q      <= pre_d;
      run_mode_q <= run_mode_d;
      term_q     <= term_d;
      done_q     <= done_d;
      running_q  <= (state_d == RUN);
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
